// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbBusy = 2'd1,
        ArbDone = 2'd2
    } arb_state_e;

    typedef enum logic {
        OwnerIf  = 1'b0,
        OwnerMem = 1'b1
    } owner_e;

    localparam logic [31:0] BusErrData = 32'hDEAD_BEEF;
    localparam logic [3:0]  SelAll     = 4'hF;

    // A zero timeout still needs a one-bit counter to keep the vector legal.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 32'd0) ? 32'd1 : $clog2(timeout + 32'd1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Saturating bus watchdog: counts un-acked BUSY cycles and flags expiry at TIMEOUT.
module bus_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned     CntW  = cnt_width(TIMEOUT);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] One   = CntW'(32'd1);

    logic [CntW-1:0] cnt_r;
    logic            sat_s;

    assign sat_s   = (cnt_r == Limit);
    assign expired = (TIMEOUT != 32'd0) && sat_s;

    // Counter holds at the limit so a long stall can never wrap to a false restart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable && !sat_s) begin
            cnt_r <= cnt_r + One;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one bus master port between IF and MEM with fixed MEM priority,
// flush-driven result discard and a watchdog-forced error completion.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ready_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        stallreq_if_o,
    output logic        stallreq_mem_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    arb_state_e  state_r;
    owner_e      owner_r;
    logic        discard_r;
    logic        bus_req_r;
    logic        bus_we_r;
    logic        bus_err_r;
    logic [3:0]  bus_sel_r;
    logic [31:0] bus_addr_r;
    logic [31:0] bus_wdata_r;
    logic [31:0] if_rdata_r;
    logic [31:0] mem_rdata_r;
    logic        wd_clear_s;
    logic        wd_enable_s;
    logic        wd_expired_s;
    logic        if_ready_s;
    logic        mem_ready_s;

    assign wd_clear_s  = (state_r != ArbBusy);
    assign wd_enable_s = (state_r == ArbBusy) && !bus_ack_i;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear_s),
        .enable  (wd_enable_s),
        .expired (wd_expired_s)
    );

    // Arbitration FSM with all bus-side and rdata outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ArbIdle;
            owner_r     <= OwnerIf;
            discard_r   <= 1'b0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_err_r   <= 1'b0;
            bus_sel_r   <= 4'h0;
            bus_addr_r  <= 32'h0;
            bus_wdata_r <= 32'h0;
            if_rdata_r  <= 32'h0;
            mem_rdata_r <= 32'h0;
        end else begin
            case (state_r)
                ArbIdle: begin
                    bus_err_r <= 1'b0;
                    // A request seen during flush belongs to a squashed instruction.
                    if (!flush_i && mem_req_i) begin
                        owner_r     <= OwnerMem;
                        bus_addr_r  <= mem_addr_i;
                        bus_we_r    <= mem_we_i;
                        bus_sel_r   <= mem_sel_i;
                        bus_wdata_r <= mem_wdata_i;
                        bus_req_r   <= 1'b1;
                        discard_r   <= 1'b0;
                        state_r     <= ArbBusy;
                    end else if (!flush_i && if_req_i) begin
                        owner_r     <= OwnerIf;
                        bus_addr_r  <= if_addr_i;
                        bus_we_r    <= 1'b0;
                        bus_sel_r   <= SelAll;
                        bus_wdata_r <= 32'h0;
                        bus_req_r   <= 1'b1;
                        discard_r   <= 1'b0;
                        state_r     <= ArbBusy;
                    end
                end
                ArbBusy: begin
                    if (flush_i) begin
                        discard_r <= 1'b1;
                    end
                    // Ack takes precedence over a simultaneous watchdog expiry.
                    if (bus_ack_i) begin
                        if (owner_r == OwnerMem) begin
                            mem_rdata_r <= bus_rdata_i;
                        end else begin
                            if_rdata_r <= bus_rdata_i;
                        end
                        bus_req_r <= 1'b0;
                        state_r   <= ArbDone;
                    end else if (wd_expired_s) begin
                        if (owner_r == OwnerMem) begin
                            mem_rdata_r <= BusErrData;
                        end else begin
                            if_rdata_r <= BusErrData;
                        end
                        bus_req_r <= 1'b0;
                        bus_err_r <= 1'b1;
                        state_r   <= ArbDone;
                    end
                end
                ArbDone: begin
                    bus_err_r <= 1'b0;
                    state_r   <= ArbIdle;
                end
                default: begin
                    bus_req_r <= 1'b0;
                    bus_err_r <= 1'b0;
                    state_r   <= ArbIdle;
                end
            endcase
        end
    end

    // Completion pulse is suppressed by a pending discard or a flush in the DONE cycle.
    always_comb begin
        if_ready_s  = 1'b0;
        mem_ready_s = 1'b0;
        if ((state_r == ArbDone) && !discard_r && !flush_i) begin
            if (owner_r == OwnerMem) begin
                mem_ready_s = 1'b1;
            end else begin
                if_ready_s = 1'b1;
            end
        end else begin
            if_ready_s  = 1'b0;
            mem_ready_s = 1'b0;
        end
    end

    assign if_ready_o     = if_ready_s;
    assign mem_ready_o    = mem_ready_s;
    assign stallreq_if_o  = rst & if_req_i & ~if_ready_s;
    assign stallreq_mem_o = rst & mem_req_i & ~mem_ready_s;
    assign if_rdata_o     = if_rdata_r;
    assign mem_rdata_o    = mem_rdata_r;
    assign bus_req_o      = bus_req_r;
    assign bus_we_o       = bus_we_r;
    assign bus_sel_o      = bus_sel_r;
    assign bus_addr_o     = bus_addr_r;
    assign bus_wdata_o    = bus_wdata_r;
    assign bus_err_o      = bus_err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences
// and a randomized transaction-level scoreboard.
module tb_mem_port_arbiter;

    localparam int TO = 8;
    localparam logic [31:0] KEY = 32'hA5A5_0F0F;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush),
        .if_req_i       (if_req),
        .if_addr_i      (if_addr),
        .if_rdata_o     (if_rdata),
        .if_ready_o     (if_ready),
        .mem_req_i      (mem_req),
        .mem_we_i       (mem_we),
        .mem_sel_i      (mem_sel),
        .mem_addr_i     (mem_addr),
        .mem_wdata_i    (mem_wdata),
        .mem_rdata_o    (mem_rdata),
        .mem_ready_o    (mem_ready),
        .stallreq_if_o  (stall_if),
        .stallreq_mem_o (stall_mem),
        .bus_req_o      (bus_req),
        .bus_we_o       (bus_we),
        .bus_sel_o      (bus_sel),
        .bus_addr_o     (bus_addr),
        .bus_wdata_o    (bus_wdata),
        .bus_rdata_i    (bus_rdata),
        .bus_ack_i      (bus_ack),
        .bus_err_o      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_n;
        logic [31:0] slave_data;
        int          flush_cyc;
        int          done_cyc;
        int          exp_ready_cyc;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_we;
        logic [3:0]  exp_sel;
    } vec_t;

    vec_t vecs[8];

    // One isolated transaction; cycle 1 is the cycle the request is first presented.
    task automatic run_vec(input int idx, input vec_t v);
        int busy_n = 0;
        int ready_cyc = 0;
        int ready_cnt = 0;
        int other_cnt = 0;
        int err_cyc = 0;
        int err_cnt = 0;
        logic [31:0] got_rdata = 32'h0;
        logic rdy;
        logic stl;
        for (int c = 1; c <= v.done_cyc + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (v.is_mem) begin
                    mem_req = 1'b1; mem_we = v.we; mem_sel = v.sel;
                    mem_addr = v.addr; mem_wdata = v.wdata;
                end else begin
                    if_req = 1'b1; if_addr = v.addr;
                end
            end
            if (c == v.done_cyc + 1) begin
                if_req = 1'b0; mem_req = 1'b0;
            end
            bus_ack = bus_req && (busy_n == v.wait_n);
            bus_rdata = bus_ack ? v.slave_data : $urandom;
            if (bus_req) busy_n++;
            flush = (c == v.flush_cyc);
            #1;
            rdy = v.is_mem ? mem_ready : if_ready;
            stl = v.is_mem ? stall_mem : stall_if;
            if (rdy) begin
                ready_cnt++;
                if (ready_cyc == 0) begin
                    ready_cyc = c;
                    got_rdata = v.is_mem ? mem_rdata : if_rdata;
                end
            end
            if (v.is_mem ? if_ready : mem_ready) other_cnt++;
            if (bus_err) begin
                err_cnt++;
                if (err_cyc == 0) err_cyc = c;
            end
            check($sformatf("v%0d_stall_c%0d", idx, c), stl,
                  (c <= v.done_cyc) && (c != v.exp_ready_cyc));
            if (c == 2) begin
                check($sformatf("v%0d_bus_req", idx), bus_req, 1'b1);
                check($sformatf("v%0d_bus_addr", idx), bus_addr, v.addr);
                check($sformatf("v%0d_bus_we", idx), bus_we, v.exp_we);
                check($sformatf("v%0d_bus_sel", idx), bus_sel, v.exp_sel);
                if (v.is_mem) check($sformatf("v%0d_bus_wdata", idx), bus_wdata, v.wdata);
            end
        end
        bus_ack = 1'b0;
        flush = 1'b0;
        check($sformatf("v%0d_ready_cycle", idx), ready_cyc, v.exp_ready_cyc);
        check($sformatf("v%0d_ready_count", idx), ready_cnt, (v.exp_ready_cyc != 0) ? 1 : 0);
        check($sformatf("v%0d_other_ready", idx), other_cnt, 0);
        check($sformatf("v%0d_err_cycle", idx), err_cyc, v.exp_err ? v.done_cyc : 0);
        check($sformatf("v%0d_err_count", idx), err_cnt, v.exp_err ? 1 : 0);
        if (v.chk_rdata) check($sformatf("v%0d_rdata", idx), got_rdata, v.exp_rdata);
    endtask

    initial begin
        bit          in_txn;
        bit          t_mem;
        bit          t_we;
        bit          snap_if;
        bit          snap_mem;
        bit          fire;
        logic [31:0] t_addr;
        logic [31:0] exp_d;
        int          cyc;
        int          g;
        int          w;
        int          pend;
        int          done_n;

        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 0, 32'h2408_0001, 0, 3, 3,
                    1'b1, 32'h2408_0001, 1'b0, 1'b0, 4'hF};
        vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h8000_0020, 32'h0, 2, 32'h1234_5678, 0, 5, 5,
                    1'b1, 32'h1234_5678, 1'b0, 1'b0, 4'hF};
        vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h8000_0010, 32'h0000_BEEF, 1, 32'h5555_AAAA, 0, 4, 4,
                    1'b0, 32'h0, 1'b0, 1'b1, 4'h3};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0, 99, 32'h1357_9BDF, 0, 11, 11,
                    1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'hF};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h0000_0108, 32'h0, 8, 32'hCAFE_F00D, 0, 11, 11,
                    1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 4'hF};
        vecs[5] = '{1'b0, 1'b0, 4'h0, 32'h0000_010C, 32'h0, 4, 32'h7777_7777, 3, 7, 0,
                    1'b0, 32'h0, 1'b0, 1'b0, 4'hF};
        vecs[6] = '{1'b1, 1'b0, 4'hF, 32'h8000_0040, 32'h0, 1, 32'h6666_6666, 3, 4, 0,
                    1'b0, 32'h0, 1'b0, 1'b0, 4'hF};
        vecs[7] = '{1'b1, 1'b0, 4'h5, 32'h8000_0044, 32'h0, 99, 32'h2468_ACE0, 0, 11, 11,
                    1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'h5};

        rst = 1'b0; flush = 1'b0; if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
        bus_rdata = 32'h0; bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_bus_req", bus_req, 1'b0);
        check("reset_bus_addr", bus_addr, 32'h0);
        check("reset_bus_sel", bus_sel, 4'h0);
        check("reset_if_rdata", if_rdata, 32'h0);
        check("reset_readies", {if_ready, mem_ready, bus_err}, 3'b000);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Simultaneous requests: MEM write first, then IF, with an always-acking slave.
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if_req = 1'b1; if_addr = 32'h0000_0100;
                mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011;
                mem_addr = 32'h8000_0010; mem_wdata = 32'h0000_BEEF;
            end
            if (c == 4) mem_req = 1'b0;
            if (c == 7) if_req = 1'b0;
            bus_ack = bus_req;
            bus_rdata = 32'h1111_2222;
            #1;
            check($sformatf("sim_bus_req_c%0d", c), bus_req, (c == 2) || (c == 5));
            check($sformatf("sim_mem_ready_c%0d", c), mem_ready, c == 3);
            check($sformatf("sim_if_ready_c%0d", c), if_ready, c == 6);
            check($sformatf("sim_stall_if_c%0d", c), stall_if, c <= 5);
            if (c == 2) check("sim_first_grant", {bus_we, bus_sel, bus_addr}, {1'b1, 4'b0011, 32'h8000_0010});
            if (c == 5) check("sim_second_grant", {bus_we, bus_sel, bus_addr}, {1'b0, 4'hF, 32'h0000_0100});
            if (c == 6) check("sim_if_rdata", if_rdata, 32'h1111_2222);
        end
        bus_ack = 1'b0;

        // Flush while idle must block the grant for that cycle only.
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin if_req = 1'b1; if_addr = 32'h0000_0200; end
            if (c == 5) if_req = 1'b0;
            flush = (c == 1);
            bus_ack = bus_req;
            bus_rdata = 32'h3333_4444;
            #1;
            check($sformatf("fidle_bus_req_c%0d", c), bus_req, c == 3);
            check($sformatf("fidle_if_ready_c%0d", c), if_ready, c == 4);
            if (c == 4) check("fidle_if_rdata", if_rdata, 32'h3333_4444);
        end
        bus_ack = 1'b0; flush = 1'b0;

        // Asynchronous reset in BUSY, then a late ack that must be ignored.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0300;
        @(negedge clk);
        check("rstmid_busy", bus_req, 1'b1);
        #2;
        rst = 1'b0; if_req = 1'b0; mem_req = 1'b1;
        #1;
        check("rstmid_bus_req", bus_req, 1'b0);
        check("rstmid_bus_addr", bus_addr, 32'h0);
        check("rstmid_stall_mem", stall_mem, 1'b0);
        check("rstmid_rdata", {if_rdata, mem_rdata}, 64'h0);
        mem_req = 1'b0;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("rstmid_after_c%0d", c), {bus_req, if_ready, mem_ready, bus_err}, 4'b0000);
            bus_ack = 1'b0;
        end
        check("rstmid_if_rdata_kept", if_rdata, 32'h0);

        // Randomized traffic against a transaction-level model.
        in_txn = 1'b0; snap_if = 1'b0; snap_mem = 1'b0; cyc = 0; g = 0; w = 0;
        pend = 0; done_n = 0; t_mem = 1'b0; t_we = 1'b0; t_addr = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cyc++;
            if (!in_txn && bus_req) begin
                if (snap_mem) begin
                    t_mem = 1'b1; t_addr = mem_addr; t_we = mem_we;
                    check("rnd_grant_mem", {bus_we, bus_sel, bus_addr, bus_wdata},
                          {mem_we, mem_sel, mem_addr, mem_wdata});
                end else if (snap_if) begin
                    t_mem = 1'b0; t_addr = if_addr; t_we = 1'b0;
                    check("rnd_grant_if", {bus_we, bus_sel, bus_addr}, {1'b0, 4'hF, if_addr});
                end else begin
                    check("rnd_spurious_grant", bus_req, 1'b0);
                end
                in_txn = 1'b1; g = cyc; w = $urandom_range(0, 10);
            end
            fire = in_txn && (cyc == g + ((w > TO) ? TO : w) + 1);
            check("rnd_if_ready", if_ready, fire && !t_mem);
            check("rnd_mem_ready", mem_ready, fire && t_mem);
            check("rnd_bus_err", bus_err, fire && (w > TO));
            check("rnd_stall_if", stall_if, if_req && !(fire && !t_mem));
            check("rnd_stall_mem", stall_mem, mem_req && !(fire && t_mem));
            if (fire) begin
                exp_d = (w > TO) ? 32'hDEAD_BEEF : (t_addr ^ KEY);
                if (!t_mem) check("rnd_if_rdata", if_rdata, exp_d);
                else if (!t_we) check("rnd_mem_rdata", mem_rdata, exp_d);
                done_n++;
                in_txn = 1'b0;
                if (t_mem) mem_req = 1'b0;
                else if_req = 1'b0;
            end
            if (in_txn && (cyc > g + TO + 3)) begin
                check("rnd_txn_stuck", cyc, g);
                in_txn = 1'b0;
            end
            if (!if_req && ($urandom_range(0, 2) == 0)) begin
                if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!mem_req && ($urandom_range(0, 3) == 0)) begin
                mem_req = 1'b1; mem_we = $urandom_range(0, 1);
                mem_sel = 4'($urandom_range(1, 15));
                mem_addr = $urandom & 32'hFFFF_FFFC; mem_wdata = $urandom;
            end
            bus_ack = in_txn && bus_req && (cyc - g == w);
            bus_rdata = bus_ack ? (t_addr ^ KEY) : $urandom;
            if (!in_txn && (if_req || mem_req)) pend++;
            else pend = 0;
            if (pend > 3) begin
                check("rnd_no_grant", pend, 0);
                pend = 0;
            end
            snap_if = if_req;
            snap_mem = mem_req;
        end
        check("rnd_enough_txns", done_n >= 100, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
